// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data wins by default; a bounded starve counter guarantees fetch progress.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  output logic                    if_ready_o,
  input  logic                    flush_i,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    d_ready_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic                    stall_f_o,
  output logic                    stall_m_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      starveCnt;
  logic                  dropQ;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic                  weQ;
  logic [DATA_WIDTH-1:0] wdataQ;
  logic [BE_W-1:0]       beQ;
  logic [DATA_WIDTH-1:0] ifDataQ;
  logic [DATA_WIDTH-1:0] dDataQ;

  logic fetchOwed;
  logic grantD;
  logic grantIf;
  logic done;

  // A flush in IDLE blocks the fetch, so an owed fetch cannot hold off data then.
  always_comb begin
    fetchOwed = if_req_i & ~flush_i & (starveCnt >= LIMIT);
    grantD    = (state == IDLE) & d_req_i & ~fetchOwed;
    grantIf   = (state == IDLE) & if_req_i & ~flush_i & (~d_req_i | fetchOwed);
    done      = (state != IDLE) & mem_ready_i;
  end

  assign if_ready_o  = done & (state == IF_BUSY) & ~dropQ & ~flush_i;
  assign d_ready_o   = done & (state == D_BUSY);
  assign if_rdata_o  = if_ready_o ? mem_rdata_i : ifDataQ;
  assign d_rdata_o   = (d_ready_o & ~weQ) ? mem_rdata_i : dDataQ;

  assign mem_req_o   = (state != IDLE);
  assign mem_we_o    = weQ;
  assign mem_addr_o  = addrQ;
  assign mem_wdata_o = wdataQ;
  assign mem_be_o    = beQ;

  assign stall_f_o   = if_req_i & ~if_ready_o;
  assign stall_m_o   = d_req_i & ~d_ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      starveCnt <= '0;
      dropQ     <= 1'b0;
      addrQ     <= '0;
      weQ       <= 1'b0;
      wdataQ    <= '0;
      beQ       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantD) begin
            state  <= D_BUSY;
            addrQ  <= d_addr_i;
            weQ    <= d_we_i;
            wdataQ <= d_wdata_i;
            beQ    <= d_be_i;
          end else if (grantIf) begin
            state  <= IF_BUSY;
            addrQ  <= if_addr_i;
            weQ    <= 1'b0;
            wdataQ <= '0;
            beQ    <= '1;
          end
          // Saturates at the limit; an owed fetch stays owed until granted.
          if (!if_req_i || grantIf)
            starveCnt <= '0;
          else if (grantD && starveCnt != LIMIT)
            starveCnt <= starveCnt + CNT_W'(1);
        end
        IF_BUSY, D_BUSY: begin
          if (mem_ready_i) begin
            state <= IDLE;
            dropQ <= 1'b0;
          end else if (state == IF_BUSY && flush_i) begin
            dropQ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ifDataQ <= '0;
      dDataQ  <= '0;
    end else begin
      if (if_ready_o)
        ifDataQ <= mem_rdata_i;
      if (d_ready_o && !weQ)
        dDataQ <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the arbiter.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int LIM = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i, flush_i, d_req_i, d_we_i, mem_ready_i;
  logic [AW-1:0] if_addr_i, d_addr_i;
  logic [DW-1:0] d_wdata_i, mem_rdata_i;
  logic [BW-1:0] d_be_i;
  logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic          if_ready_o, d_ready_o, mem_req_o, mem_we_o, stall_f_o, stall_m_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;

  always #10 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .flush_i(flush_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_ready_o(d_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_f_o(stall_f_o), .stall_m_o(stall_m_o)
  );

  int passCnt = 0;
  int totalCnt = 0;
  int failCnt = 0;

  // reference model: which port owns the memory (0 none, 1 fetch, 2 data)
  int            mBusy, mStarve;
  logic [AW-1:0] mAddr;
  logic          mWe, mDrop;
  logic [DW-1:0] mWdata, mIfData, mDData;
  logic [BW-1:0] mBe;

  // memory responder and requester knobs
  int            memCnt, memLat;
  bit            memRandLat, memJunk, memRandData;
  logic [DW-1:0] memData;
  int            ifMode, dMode;   // 0 drop after ready, 1 keep requesting, 2 random
  bit            randFlush;
  int            ifReadyCnt, dReadyCnt, stepNo;
  bit            sawIf, sawD, recOn, prevReq;
  logic [AW-1:0] recQ[$];
  int            recT[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mStarve = 0; mAddr = '0; mWe = 1'b0; mDrop = 1'b0;
    mWdata = '0; mIfData = '0; mDData = '0; mBe = '0;
  endtask

  task automatic step();
    logic done, expIfR, expDR;
    bit   fetchOwed;
    #1;
    if (mem_req_o) begin
      mem_ready_i = (memCnt >= memLat);
      memCnt = mem_ready_i ? 0 : memCnt + 1;
    end else begin
      memCnt = 0;
      mem_ready_i = memJunk ? 1'($urandom % 2) : 1'b0;
      if (memRandLat) memLat = int'($urandom % 4);
    end
    mem_rdata_i = memRandData ? $urandom : memData;
    #1;
    if (!rst_i) modelReset();
    done   = (mBusy != 0) && mem_ready_i;
    expIfR = done && (mBusy == 1) && !mDrop && !flush_i;
    expDR  = done && (mBusy == 2);
    check("mem_req",   64'(mem_req_o),   64'(mBusy != 0));
    check("mem_addr",  64'(mem_addr_o),  64'(mAddr));
    check("mem_we",    64'(mem_we_o),    64'(mWe));
    check("mem_wdata", 64'(mem_wdata_o), 64'(mWdata));
    check("mem_be",    64'(mem_be_o),    64'(mBe));
    check("if_ready",  64'(if_ready_o),  64'(expIfR));
    check("d_ready",   64'(d_ready_o),   64'(expDR));
    check("if_rdata",  64'(if_rdata_o),  64'(expIfR ? mem_rdata_i : mIfData));
    check("d_rdata",   64'(d_rdata_o),   64'((expDR && !mWe) ? mem_rdata_i : mDData));
    check("stall_f",   64'(stall_f_o),   64'(if_req_i && !expIfR));
    check("stall_m",   64'(stall_m_o),   64'(d_req_i && !expDR));
    sawIf = if_ready_o;
    sawD  = d_ready_o;
    if (if_ready_o) ifReadyCnt++;
    if (d_ready_o) dReadyCnt++;
    if (recOn && mem_req_o && !prevReq) begin
      recQ.push_back(mem_addr_o);
      recT.push_back(stepNo);
    end
    prevReq = mem_req_o;
    stepNo++;
    if (rst_i) begin
      if (mBusy != 0) begin
        if (mem_ready_i) begin
          if (expIfR) mIfData = mem_rdata_i;
          if (expDR && !mWe) mDData = mem_rdata_i;
          mBusy = 0;
          mDrop = 1'b0;
        end else if (mBusy == 1 && flush_i) begin
          mDrop = 1'b1;
        end
      end else begin
        fetchOwed = if_req_i && !flush_i && (mStarve >= LIM);
        if (d_req_i && !fetchOwed) begin
          mBusy = 2; mAddr = d_addr_i; mWe = d_we_i; mWdata = d_wdata_i; mBe = d_be_i;
          if (if_req_i) mStarve++;
        end else if (if_req_i && !flush_i) begin
          mBusy = 1; mAddr = if_addr_i; mWe = 1'b0; mWdata = '0; mBe = '1;
          mStarve = 0;
        end
        if (!if_req_i) mStarve = 0;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    if (ifMode == 0 && sawIf) if_req_i = 1'b0;
    if (ifMode == 2) begin
      if (!if_req_i || sawIf) begin
        if_req_i  = 1'($urandom % 2);
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      flush_i = randFlush && ($urandom % 10 == 0);
      if (flush_i && if_req_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
    end
    if (dMode == 0 && sawD) d_req_i = 1'b0;
    if (dMode == 2 && (!d_req_i || sawD)) begin
      d_req_i   = 1'($urandom % 2);
      d_we_i    = 1'($urandom % 2);
      d_addr_i  = $urandom & 32'hFFFF_FFFC;
      d_wdata_i = $urandom;
      d_be_i    = BW'($urandom);
    end
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (!mem_req_o && n < 8) begin
      step();
      n++;
    end
    check(tag, 64'(mem_req_o), 64'(1));
  endtask

  initial begin
    int k, n;
    logic [AW-1:0] expOrder[8];
    rst_i = 1'b0;
    if_req_i = 1'b0; flush_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    mem_ready_i = 1'b0; mem_rdata_i = '0;
    memCnt = 0; memLat = 2; memRandLat = 0; memJunk = 0; memRandData = 0; memData = '0;
    ifMode = 0; dMode = 0; randFlush = 0;
    ifReadyCnt = 0; dReadyCnt = 0; stepNo = 0; recOn = 0; prevReq = 0;
    modelReset();

    @(negedge clk_i);
    #1;
    check("rst_mem_req",  64'(mem_req_o),  64'(0));
    check("rst_mem_addr", 64'(mem_addr_o), 64'(0));
    check("rst_if_ready", 64'(if_ready_o), 64'(0));
    step();
    step();
    rst_i = 1'b1;
    step();

    // single fetch, memory answers two cycles after the request rises
    memLat = 2; memData = 32'h0050_0093;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    waitReq("t038_req");
    check("t038_addr", 64'(mem_addr_o), 64'(32'h100));
    k = 0;
    do begin step(); k++; end while (!sawIf && k < 10);
    check("t038_lat", 64'(k), 64'(3));
    check("t038_rdata", 64'(if_rdata_o), 64'(32'h0050_0093));
    step();

    // simultaneous requests: data first, fetch after one idle cycle
    memLat = 1; memData = 32'hCAFE_F00D;
    recQ.delete(); recT.delete(); recOn = 1;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    d_addr_i = 32'h2000; d_we_i = 1'b0; d_req_i = 1'b1;
    repeat (10) step();
    recOn = 0;
    check("t039_grants", 64'(recQ.size()), 64'(2));
    if (recQ.size() >= 2) begin
      check("t039_first",  64'(recQ[0]), 64'(32'h2000));
      check("t039_second", 64'(recQ[1]), 64'(32'h100));
      check("t039_gap",    64'(recT[1] - recT[0]), 64'(3));
    end
    check("t039_drdata",  64'(d_rdata_o),  64'(32'hCAFE_F00D));
    check("t039_ifrdata", 64'(if_rdata_o), 64'(32'hCAFE_F00D));

    // store keeps the load data register untouched
    d_addr_i = 32'h40; d_we_i = 1'b1; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011; d_req_i = 1'b1;
    waitReq("t041_req");
    check("t041_we",    64'(mem_we_o),    64'(1));
    check("t041_be",    64'(mem_be_o),    64'(4'b0011));
    check("t041_wdata", 64'(mem_wdata_o), 64'(32'hDEAD_BEEF));
    check("t041_addr",  64'(mem_addr_o),  64'(32'h40));
    n = dReadyCnt; k = 0;
    do begin step(); k++; end while (!sawD && k < 10);
    check("t041_done", 64'(sawD), 64'(1));
    step();
    check("t041_pulse",  64'(dReadyCnt - n), 64'(1));
    check("t041_drdata", 64'(d_rdata_o),     64'(32'hCAFE_F00D));

    // continuous traffic: three data grants, then the owed fetch
    step(); step();
    memLat = 0; ifMode = 1; dMode = 1;
    recQ.delete(); recT.delete(); recOn = 1;
    if_addr_i = 32'h1000; if_req_i = 1'b1;
    d_addr_i = 32'h2000; d_we_i = 1'b0; d_req_i = 1'b1;
    k = 0;
    while (recQ.size() < 8 && k < 60) begin step(); k++; end
    recOn = 0;
    expOrder = '{32'h2000, 32'h2000, 32'h2000, 32'h1000, 32'h2000, 32'h2000, 32'h2000, 32'h1000};
    check("t040_count", 64'(recQ.size() >= 8), 64'(1));
    for (int i = 0; i < 8; i++)
      if (i < recQ.size()) check($sformatf("t040_grant%0d", i), 64'(recQ[i]), 64'(expOrder[i]));
    if_req_i = 1'b0; d_req_i = 1'b0;
    repeat (4) step();
    ifMode = 0; dMode = 0;

    // flush during a fetch: transaction runs out silently
    memLat = 3; memData = 32'h0BAD_0BAD;
    if_addr_i = 32'h300; if_req_i = 1'b1;
    waitReq("t042_req");
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; if_req_i = 1'b0;
    n = ifReadyCnt; k = 0;
    while (mem_req_o && k < 10) begin step(); k++; end
    check("t042_hold",   64'(k),                64'(3));
    check("t042_noready", 64'(ifReadyCnt - n),  64'(0));
    check("t042_rdata",  64'(if_rdata_o),       64'(32'hCAFE_F00D));

    // reset in the middle of a data access
    memLat = 5; memData = 32'h1111_2222;
    d_addr_i = 32'h3000; d_we_i = 1'b0; d_req_i = 1'b1;
    waitReq("t043_req");
    step();
    rst_i = 1'b0;
    #1;
    check("t043_req_drop", 64'(mem_req_o), 64'(0));
    check("t043_no_ready", 64'(d_ready_o), 64'(0));
    memJunk = 1; n = dReadyCnt;
    step(); step();
    check("t043_ready_cnt", 64'(dReadyCnt - n), 64'(0));
    check("t043_drdata",    64'(d_rdata_o),     64'(0));
    rst_i = 1'b1;
    #1;
    check("t043_idle", 64'(mem_req_o), 64'(0));
    step();
    check("t043_regrant", 64'(mem_req_o),  64'(1));
    check("t043_addr",    64'(mem_addr_o), 64'(32'h3000));
    k = 0;
    do begin step(); k++; end while (!sawD && k < 12);
    check("t043_done", 64'(sawD), 64'(1));

    // randomized traffic with flushes, variable latency and stray readies
    ifMode = 2; dMode = 2; randFlush = 1;
    memRandLat = 1; memRandData = 1; memJunk = 1;
    repeat (1500) step();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passCnt, totalCnt);
    $fatal(1, "watchdog expired");
  end

endmodule
